// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port, shared by EX and MEM writeback,
// plus a per-register scoreboard of outstanding loads that feeds decode's RAW-hazard stall.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int SEL_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [SEL_W-1:0]  ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [SEL_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              pend_set,
  input  logic [SEL_W-1:0]  pend_rd,
  input  logic [SEL_W-1:0]  rs1_q,
  input  logic [SEL_W-1:0]  rs2_q,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rd_w,
  output logic [SEL_W-1:0]  rd_sel,
  output logic [DATA_W-1:0] rd_in,
  output logic              idle
);

  typedef enum logic {
    GRANT_EX  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  grant_e            last_grant_reg;
  grant_e            last_grant_next;
  logic              grant_ex;
  logic              grant_mem;
  logic              any_grant;
  logic [SEL_W-1:0]  win_rd;
  logic [DATA_W-1:0] win_data;
  logic [NREG-1:0]   pending_reg;
  logic [NREG-1:0]   pending_next;
  logic              rd_w_reg;
  logic [SEL_W-1:0]  rd_sel_reg;
  logic [DATA_W-1:0] rd_in_reg;

  // A tie goes to whichever requester was not served last.
  always_comb begin
    grant_ex        = ex_valid;
    grant_mem       = mem_valid;
    last_grant_next = last_grant_reg;
    if (ex_valid && mem_valid) begin
      grant_ex  = (last_grant_reg == GRANT_MEM);
      grant_mem = (last_grant_reg == GRANT_EX);
    end
    if (grant_ex) begin
      last_grant_next = GRANT_EX;
    end else if (grant_mem) begin
      last_grant_next = GRANT_MEM;
    end
  end

  assign any_grant = grant_ex || grant_mem;
  assign win_rd    = grant_mem ? mem_rd : ex_rd;
  assign win_data  = grant_mem ? mem_data : ex_data;
  assign ex_ready  = grant_ex;
  assign mem_ready = grant_mem;

  // A load issued to the same register the MEM writeback is retiring supersedes the clear.
  assign pending_next[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_pend
      logic set_hit;
      logic clr_hit;
      assign set_hit = pend_set && (pend_rd == SEL_W'(gi));
      assign clr_hit = grant_mem && (mem_rd == SEL_W'(gi));
      assign pending_next[gi] = set_hit || (pending_reg[gi] && !clr_hit);
    end
  endgenerate

  // A register being written back this cycle stays busy until the write lands in the output register.
  assign rs1_busy = (rs1_q != '0) && (pending_reg[rs1_q] || (grant_mem && (mem_rd == rs1_q)));
  assign rs2_busy = (rs2_q != '0) && (pending_reg[rs2_q] || (grant_mem && (mem_rd == rs2_q)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_reg <= GRANT_MEM;
      pending_reg    <= '0;
      rd_w_reg       <= 1'b0;
      rd_sel_reg     <= '0;
      rd_in_reg      <= '0;
    end else begin
      last_grant_reg <= last_grant_next;
      pending_reg    <= pending_next;
      rd_w_reg       <= any_grant && (win_rd != '0);
      if (any_grant) begin
        rd_sel_reg <= win_rd;
        rd_in_reg  <= win_data;
      end
    end
  end

  assign rd_w   = rd_w_reg;
  assign rd_sel = rd_sel_reg;
  assign rd_in  = rd_in_reg;
  assign idle   = (pending_reg == '0) && !rd_w_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios then randomized traffic,
// checked against a register-level behavioural model of grants, pending loads and writes.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int SW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ex_valid = 1'b0, mem_valid = 1'b0, pend_set = 1'b0;
  logic [SW-1:0] ex_rd = '0, mem_rd = '0, pend_rd = '0, rs1_q = '0, rs2_q = '0;
  logic [DW-1:0] ex_data = '0, mem_data = '0;
  logic          ex_ready, mem_ready, rs1_busy, rs2_busy, rd_w, idle;
  logic [SW-1:0] rd_sel;
  logic [DW-1:0] rd_in;

  regfile_wb_arbiter #(.DATA_W(DW), .NREG(NR), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .pend_set(pend_set), .pend_rd(pend_rd),
    .rs1_q(rs1_q), .rs2_q(rs2_q), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rd_w(rd_w), .rd_sel(rd_sel), .rd_in(rd_in), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  bit  started = 1'b0;

  // Reference model state: which registers await a load, who was served last, whether a write is due now.
  bit  pend_m[NR];
  bit  last_was_mem;
  bit  exp_rdw;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit none_pending();
    for (int i = 0; i < NR; i++) if (pend_m[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) pend_m[i] = 1'b0;
    last_was_mem = 1'b1;
    exp_rdw      = 1'b0;
    exp_q.delete();
  endtask

  // One clock cycle: drive, check combinational outputs against the model, then advance the model.
  task automatic do_cycle(
    input bit ev, input logic [SW-1:0] erd, input logic [DW-1:0] ed,
    input bit mv, input logic [SW-1:0] mrd, input logic [DW-1:0] md,
    input bit ps, input logic [SW-1:0] prd,
    input logic [SW-1:0] q1, input logic [SW-1:0] q2,
    output bit o_er, output bit o_mr, output bit o_b1, output bit o_b2, output bit o_idle);
    bit ge, gm, b1, b2;
    wr_t w;
    @(posedge clk); #1;
    ex_valid = ev;  ex_rd = erd;  ex_data = ed;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    pend_set = ps;  pend_rd = prd;
    rs1_q = q1;     rs2_q = q2;
    @(negedge clk);
    if (ev && mv) begin
      ge = last_was_mem;
      gm = !last_was_mem;
    end else begin
      ge = ev;
      gm = mv;
    end
    b1 = (q1 != 0) && (pend_m[q1] || (gm && mrd == q1));
    b2 = (q2 != 0) && (pend_m[q2] || (gm && mrd == q2));
    o_er = ex_ready; o_mr = mem_ready; o_b1 = rs1_busy; o_b2 = rs2_busy; o_idle = idle;
    chk("ex_ready", ex_ready, ge);
    chk("mem_ready", mem_ready, gm);
    chk("rs1_busy", rs1_busy, b1);
    chk("rs2_busy", rs2_busy, b2);
    chk("idle", idle, none_pending() && !exp_rdw);
    if (ge) last_was_mem = 1'b0;
    if (gm) last_was_mem = 1'b1;
    exp_rdw = 1'b0;
    if (ge && erd != 0) begin w.sel = erd; w.data = ed; exp_q.push_back(w); exp_rdw = 1'b1; end
    if (gm && mrd != 0) begin w.sel = mrd; w.data = md; exp_q.push_back(w); exp_rdw = 1'b1; end
    if (gm) pend_m[mrd] = 1'b0;
    if (ps && prd != 0) pend_m[prd] = 1'b1;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_valid = 1'b0; pend_set = 1'b0;
    rs1_q = 5'd7; rs2_q = 5'd9;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_rd_w", rd_w, 1'b0);
    chk("rst_rd_sel", rd_sel, '0);
    chk("rst_rd_in", rd_in, '0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_busy1", rs1_busy, 1'b0);
    chk("rst_busy2", rs2_busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: every presented write must match the oldest expected write.
  initial begin
    wr_t e;
    wait (started);
    forever begin
      @(posedge clk); #3;
      if (!rst) begin
        chk("rd_w", rd_w, exp_rdw);
        if (rd_w === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL wr_unexpected: got rd_sel=%0d rd_in=%h, expected no write", rd_sel, rd_in);
          end else begin
            e = exp_q.pop_front();
            chk("rd_sel", rd_sel, e.sel);
            chk("rd_in", rd_in, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit er, mr, b1, b2, id;
    bit ex_hold, mem_hold, ev, mv, ps;
    logic [SW-1:0] erd, mrd, prd, q1, q2;
    logic [DW-1:0] ed, md;

    #1 rst = 1'b1;
    model_reset();
    #3;
    chk("init_rd_w", rd_w, 1'b0);
    chk("init_rd_sel", rd_sel, '0);
    chk("init_rd_in", rd_in, '0);
    chk("init_idle", idle, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    started = 1'b1;

    // Round-robin tie straight out of reset: EX, MEM, EX, MEM.
    for (int k = 0; k < 4; k++) begin
      do_cycle(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 0, 0, 0, er, mr, b1, b2, id);
      chk("rr_ex_ready", er, (k % 2) == 0);
    end
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, er, mr, b1, b2, id);

    // Single EX write.
    do_cycle(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, er, mr, b1, b2, id);
    chk("single_ex_ready", er, 1'b1);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, er, mr, b1, b2, id);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, er, mr, b1, b2, id);

    // Load hazard lifecycle on x7.
    do_cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0, er, mr, b1, b2, id);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0, er, mr, b1, b2, id);
    chk("hz_busy_set", b1, 1'b1);
    chk("hz_idle_low", id, 1'b0);
    do_cycle(0, 0, 0, 1, 5'd7, 32'hCAFE0007, 0, 0, 5'd7, 0, er, mr, b1, b2, id);
    chk("hz_busy_grant", b1, 1'b1);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0, er, mr, b1, b2, id);
    chk("hz_busy_clear", b1, 1'b0);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0, er, mr, b1, b2, id);
    chk("hz_idle_back", id, 1'b1);

    // Set and clear of x9 in the same cycle: the new load wins.
    do_cycle(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 5'd9, er, mr, b1, b2, id);
    do_cycle(0, 0, 0, 1, 5'd9, 32'h99, 1, 5'd9, 0, 5'd9, er, mr, b1, b2, id);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9, er, mr, b1, b2, id);
    chk("coll_busy", b2, 1'b1);
    do_cycle(0, 0, 0, 1, 5'd9, 32'h999, 0, 0, 0, 0, er, mr, b1, b2, id);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, er, mr, b1, b2, id);

    // x0: accepted but never written, never pending.
    do_cycle(1, 5'd0, 32'h12345678, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, er, mr, b1, b2, id);
    chk("x0_ready", er, 1'b1);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0, er, mr, b1, b2, id);
    chk("x0_busy", b1, 1'b0);
    chk("x0_idle", id, 1'b1);

    // Randomized traffic obeying the hold-until-ready protocol, with a reset mid-stream.
    ex_hold = 0; mem_hold = 0;
    ev = 0; mv = 0; erd = 0; mrd = 0; ed = 0; md = 0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        apply_reset();
        ex_hold = 0; mem_hold = 0;
      end
      if (!ex_hold) begin
        ev  = ($urandom_range(0, 2) != 0);
        erd = SW'($urandom_range(0, 7));
        ed  = $urandom;
      end
      if (!mem_hold) begin
        mv  = ($urandom_range(0, 2) != 0);
        mrd = SW'($urandom_range(0, 7));
        md  = $urandom;
      end
      ps  = ($urandom_range(0, 3) == 0);
      prd = SW'($urandom_range(0, 7));
      q1  = SW'($urandom_range(0, 7));
      q2  = SW'($urandom_range(0, 7));
      do_cycle(ev, erd, ed, mv, mrd, md, ps, prd, q1, q2, er, mr, b1, b2, id);
      ex_hold  = ev && !er;
      mem_hold = mv && !mr;
    end
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, er, mr, b1, b2, id);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, er, mr, b1, b2, id);
    @(posedge clk); #5;
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Sequences the register file's single write port between two writeback requesters: the execute stage (EX) and the load/memory unit (MEM).
- Keeps a pending-write scoreboard of destination registers with outstanding loads, so the decode stage can stall on RAW hazards.
- Write-port outputs are registered on posedge clk. The register file captures them on the following negedge.

Parameters:
- DATA_W, 32, width of writeback data.
- NREG, 32, number of architectural registers. Register 0 is hardwired zero.
- SEL_W, 5, register select width, equal to clog2(NREG).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- ex_valid  in  1  EX has a result to write back.
- ex_ready  out  1  EX result granted this cycle (combinational).
- ex_rd  in  SEL_W  EX destination register.
- ex_data  in  DATA_W  EX result.
- mem_valid  in  1  MEM has load data to write back.
- mem_ready  out  1  MEM result granted this cycle (combinational).
- mem_rd  in  SEL_W  MEM destination register.
- mem_data  in  DATA_W  load data.
- pend_set  in  1  decode issued a load; mark pend_rd pending.
- pend_rd  in  SEL_W  destination of the issued load.
- rs1_q  in  SEL_W  decode source-1 hazard query.
- rs2_q  in  SEL_W  decode source-2 hazard query.
- rs1_busy  out  1  rs1_q has an outstanding load (combinational).
- rs2_busy  out  1  rs2_q has an outstanding load (combinational).
- rd_w  out  1  register file write enable (registered).
- rd_sel  out  SEL_W  register file write select (registered).
- rd_in  out  DATA_W  register file write data (registered).
- idle  out  1  no pending loads and rd_w low.

Behaviour:
- Reset (async, rst=1):
  - rd_w=0, rd_sel=0, rd_in=0.
  - Pending vector all 0.
  - last_grant=MEM, so the first tie goes to EX.
  - idle=1, busy outputs 0.
- Arbitration, combinational each cycle:
  - Only EX valid: grant EX. Only MEM valid: grant MEM. Neither: no grant.
  - Both valid: grant the requester that is not last_grant (round-robin).
  - last_grant updates on every grant, including single-requester grants.
  - ex_ready = grant_EX; mem_ready = grant_MEM. They are never both 1.
  - A requester holds valid/rd/data stable until its ready is seen. There is no other backpressure; the port accepts one write per cycle.
- Write register, posedge after a grant:
  - rd_w=1, rd_sel=granted rd, rd_in=granted data.
  - Granted rd=0: request is accepted (ready=1) but rd_w=0 next cycle and rd_sel/rd_in are don't-care.
  - No grant: rd_w=0 next cycle; rd_sel/rd_in hold.
  - Latency: grant in cycle N; rd_w high during N+1; register file captures at the negedge of N+1.
- Scoreboard, one bit per register; bit 0 is always 0:
  - Set: pend_set with pend_rd≠0 sets bit[pend_rd] at posedge.
  - Clear: a MEM grant clears bit[mem_rd] at posedge. Clearing a non-pending register is a no-op.
  - Same register set and cleared in the same cycle: set wins, because the new load supersedes.
  - EX grants never touch the scoreboard.
- Hazard outputs:
  - rsN_busy = pending[rsN_q] OR (MEM grant this cycle AND mem_rd==rsN_q AND rsN_q≠0).
  - A register being written this cycle stays busy until its write is in the write register.
  - rsN_q=0 always gives busy=0.
- idle = (pending==0) AND !rd_w.
- Reset mid-operation: all state clears immediately. In-flight grants are lost, and requesters must re-present after reset.

Test Plan:
- Reset then idle: rst pulse with no requests -> rd_w=0, rd_sel=0, rd_in=0, idle=1, busy=0 for any query.
- Single EX write: ex_valid, ex_rd=5, ex_data=0xDEADBEEF in cycle N -> ex_ready=1 in N; rd_w=1, rd_sel=5, rd_in=0xDEADBEEF in N+1; rd_w=0 in N+2.
- Round-robin tie: EX(rd=1, 0x11) and MEM(rd=2, 0x22) held valid for 4 cycles, each re-presenting after grant -> grants EX, MEM, EX, MEM; rd_sel sequence 1, 2, 1, 2 offset one cycle.
- Load hazard lifecycle:
  - pend_set with pend_rd=7 -> rs1_busy=1 for rs1_q=7 from the next cycle; idle=0.
  - mem_valid, mem_rd=7 granted in N -> busy=1 in N, 0 in N+1; idle=1 in N+2.
- Set/clear collision: pend_set with pend_rd=9 in the same cycle as a MEM grant to rd=9 (bit previously set) -> bit 9 remains set, rs2_busy=1 for rs2_q=9 the next cycle.
- x0 handling: ex_rd=0 granted -> ex_ready=1, rd_w=0 next cycle; pend_set with pend_rd=0 -> rs1_busy(rs1_q=0)=0, idle stays 1.
